// File: rtl/spi_slv_pkg.sv
// Shared types and helpers for the SPI slave responder.
package spi_slv_pkg;

  // Frame state: waiting for slave select, or exchanging words.
  typedef enum logic {
    StIdle,
    StShift
  } state_e;

  // Mode configuration captured at the start of each frame.
  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } cfg_t;

  // Depth of the optional receive FIFO.
  localparam int unsigned RxFifoDepth = 4;

  // Leading edge leaves the idle level, trailing edge returns to it.
  function automatic logic sample_edge(cfg_t cfg, logic rise, logic fall);
    logic lead;
    logic trail;
    lead  = cfg.cpol ? fall : rise;
    trail = cfg.cpol ? rise : fall;
    return cfg.cpha ? trail : lead;
  endfunction

  function automatic logic shift_edge(cfg_t cfg, logic rise, logic fall);
    logic lead;
    logic trail;
    lead  = cfg.cpol ? fall : rise;
    trail = cfg.cpol ? rise : fall;
    return cfg.cpha ? lead : trail;
  endfunction

endpackage

// File: rtl/spi_slv_sync.sv
// Two-flop synchroniser with a third flop for edge detection, one lane per bit.
module spi_slv_sync #(
  parameter int unsigned      Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;
  logic [Width-1:0] prev_q;

  // Synchronise the asynchronous pins and keep one cycle of history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
      prev_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI slave responder: synchronised full-duplex shift engine for all four
// CPOL/CPHA modes, a TX holding register and a valid/ready RX output.
// Define SPI_SLV_RX_FIFO_EN to replace the single RX register with a small FIFO.
module spi_slave_responder
  import spi_slv_pkg::*;
#(
  parameter int unsigned       DATA_W     = 8,
  parameter logic [DATA_W-1:0] DUMMY_WORD = '1
) (
  input  logic              pclk,
  input  logic              p_reset,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic              cfg_lsb_first,
  input  logic              sclk_in,
  input  logic              n_ss_in,
  input  logic              si,
  output logic              so,
  output logic              n_so_en,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              underrun,
  output logic              busy
);

  localparam int unsigned     CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  function automatic logic first_bit(logic [DATA_W-1:0] w, logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(logic [DATA_W-1:0] w, logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(logic [DATA_W-1:0] w, logic b, logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  // Pin vector: {sclk, n_ss, si}; n_ss resets high so reset never looks like a frame start.
  logic [2:0] pins_s, pins_rise, pins_fall;

  spi_slv_sync #(
    .Width   (3),
    .ResetVal(3'b010)
  ) u_sync (
    .clk_i (pclk),
    .rst_i (p_reset),
    .d_i   ({sclk_in, n_ss_in, si}),
    .q_o   (pins_s),
    .rise_o(pins_rise),
    .fall_o(pins_fall)
  );

  logic sclk_rise, sclk_fall, ss_rise, ss_fall, si_s;
  logic unused_pins;
  assign sclk_rise   = pins_rise[2];
  assign sclk_fall   = pins_fall[2];
  assign ss_rise     = pins_rise[1];
  assign ss_fall     = pins_fall[1];
  assign si_s        = pins_s[0];
  assign unused_pins = ^{pins_s[2:1], pins_rise[0], pins_fall[0]};

  state_e            state_q;
  cfg_t              cfg_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [DATA_W-1:0] tx_sr_q;
  logic [DATA_W-1:0] rx_sr_q;
  logic              so_q, n_so_en_q, busy_q, underrun_q, dummy_pend_q;
  logic [DATA_W-1:0] tx_hold_q;
  logic              tx_full_q;

  cfg_t              cfg_in, load_cfg;
  logic              frame_start, in_shift, sample_evt, shift_evt, word_done, word_load;
  logic [DATA_W-1:0] load_word, tx_sr_load, rx_sr_d;
  logic              so_load;

  // Decode synchronised pin events into frame/bit events and the next word to load.
  always_comb begin
    cfg_in      = '{cpol: cfg_cpol, cpha: cfg_cpha, lsb_first: cfg_lsb_first};
    frame_start = (state_q == StIdle) && ss_fall;
    in_shift    = (state_q == StShift) && !ss_rise;
    sample_evt  = in_shift && sample_edge(cfg_q, sclk_rise, sclk_fall);
    // With CPHA=0 the first bit was presented at load, so the trailing edge
    // that follows a word load must not advance the shifter.
    shift_evt   = in_shift && shift_edge(cfg_q, sclk_rise, sclk_fall) &&
                  (cfg_q.cpha || (bit_cnt_q != '0));
    word_done   = sample_evt && (bit_cnt_q == LastBit);
    word_load   = frame_start || word_done;
    load_cfg    = frame_start ? cfg_in : cfg_q;
    load_word   = tx_full_q ? tx_hold_q : DUMMY_WORD;
    so_load     = first_bit(load_word, load_cfg.lsb_first);
    tx_sr_load  = load_cfg.cpha ? load_word : shift_out(load_word, load_cfg.lsb_first);
    rx_sr_d     = shift_in(rx_sr_q, si_s, cfg_q.lsb_first);
  end

  // Frame FSM and shift engine with registered MISO, enable, busy and underrun.
  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      state_q      <= StIdle;
      cfg_q        <= '0;
      bit_cnt_q    <= '0;
      tx_sr_q      <= '0;
      rx_sr_q      <= '0;
      so_q         <= 1'b0;
      n_so_en_q    <= 1'b1;
      busy_q       <= 1'b0;
      underrun_q   <= 1'b0;
      dummy_pend_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ss_fall) begin
            state_q      <= StShift;
            cfg_q        <= cfg_in;
            n_so_en_q    <= 1'b0;
            busy_q       <= 1'b1;
            bit_cnt_q    <= '0;
            tx_sr_q      <= tx_sr_load;
            underrun_q   <= !tx_full_q;
            dummy_pend_q <= 1'b0;
            if (!cfg_in.cpha) so_q <= so_load;
          end
        end
        StShift: begin
          if (ss_rise) begin
            state_q      <= StIdle;
            n_so_en_q    <= 1'b1;
            busy_q       <= 1'b0;
            bit_cnt_q    <= '0;
            dummy_pend_q <= 1'b0;
          end else if (sample_evt) begin
            rx_sr_q <= rx_sr_d;
            // A dummy reloaded at word end only counts once the master clocks it.
            if ((bit_cnt_q == '0) && dummy_pend_q) begin
              underrun_q   <= 1'b1;
              dummy_pend_q <= 1'b0;
            end
            if (word_done) begin
              bit_cnt_q    <= '0;
              tx_sr_q      <= tx_sr_load;
              dummy_pend_q <= !tx_full_q;
              if (!cfg_q.cpha) so_q <= so_load;
            end else begin
              bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
          end else if (shift_evt) begin
            so_q    <= first_bit(tx_sr_q, cfg_q.lsb_first);
            tx_sr_q <= shift_out(tx_sr_q, cfg_q.lsb_first);
          end
        end
      endcase
    end
  end

  // TX holding register: filled by a valid/ready handshake, emptied at each word load.
  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      tx_hold_q <= '0;
      tx_full_q <= 1'b0;
    end else begin
      if (word_load && tx_full_q) begin
        tx_full_q <= 1'b0;
      end else if (tx_valid && !tx_full_q) begin
        tx_hold_q <= tx_data;
        tx_full_q <= 1'b1;
      end
    end
  end

  assign so       = so_q;
  assign n_so_en  = n_so_en_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;
  assign tx_ready = !tx_full_q;

`ifdef SPI_SLV_RX_FIFO_EN
  localparam int unsigned      PtrW     = $clog2(RxFifoDepth);
  localparam logic [PtrW:0]    FifoFull = (PtrW + 1)'(RxFifoDepth);

  logic [DATA_W-1:0] fifo_q [RxFifoDepth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q;
  logic              overrun_q;
  logic              pop, push_ok;

  assign pop     = (count_q != '0) && rx_ready;
  assign push_ok = word_done && ((count_q != FifoFull) || pop);

  // RX FIFO: a push into a full FIFO is dropped unless a pop frees a slot that cycle.
  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      for (int i = 0; i < int'(RxFifoDepth); i++) fifo_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= word_done && !push_ok;
      if (push_ok) begin
        fifo_q[wr_ptr_q] <= rx_sr_d;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_ok && !pop) begin
        count_q <= count_q + (PtrW + 1)'(1);
      end else if (!push_ok && pop) begin
        count_q <= count_q - (PtrW + 1)'(1);
      end
    end
  end

  assign rx_data  = fifo_q[rd_ptr_q];
  assign rx_valid = (count_q != '0);
  assign overrun  = overrun_q;
`else
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q, overrun_q;

  // Single RX register: a push that finds an unconsumed word is dropped.
  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (word_done) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= rx_sr_d;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder acting as the SPI master.
module tb_spi_slave_responder;

  logic       pclk = 1'b0;
  logic       p_reset = 1'b1;
  logic       cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb_first = 1'b0;
  logic       sclk_in = 1'b0, n_ss_in = 1'b1, si = 1'b0;
  logic       so, n_so_en, tx_ready, rx_valid, overrun, underrun, busy;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic [7:0] rx_data;
  logic       rx_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int under_cnt = 0, over_cnt = 0, push_cnt = 0;
  logic rx_valid_prev = 1'b0;

  spi_slave_responder dut (
    .pclk         (pclk),
    .p_reset      (p_reset),
    .cfg_cpol     (cfg_cpol),
    .cfg_cpha     (cfg_cpha),
    .cfg_lsb_first(cfg_lsb_first),
    .sclk_in      (sclk_in),
    .n_ss_in      (n_ss_in),
    .si           (si),
    .so           (so),
    .n_so_en      (n_so_en),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .overrun      (overrun),
    .underrun     (underrun),
    .busy         (busy)
  );

  always #5 pclk = ~pclk;

  // Event counters for pulses and rx_valid rises.
  always @(negedge pclk) begin
    if (underrun) under_cnt <= under_cnt + 1;
    if (overrun) over_cnt <= over_cnt + 1;
    if (rx_valid && !rx_valid_prev) push_cnt <= push_cnt + 1;
    rx_valid_prev <= rx_valid;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic half_sclk();
    repeat (8) @(negedge pclk);
  endtask

  function automatic logic mbit(logic [39:0] v, int i, logic lsb);
    logic [7:0] w;
    int j;
    w = v[8*(i/8) +: 8];
    j = i % 8;
    return lsb ? w[j] : w[7-j];
  endfunction

  task automatic do_reset();
    p_reset  = 1'b1;
    n_ss_in  = 1'b1;
    sclk_in  = 1'b0;
    si       = 1'b0;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    repeat (3) @(negedge pclk);
    p_reset = 1'b0;
    repeat (4) @(negedge pclk);
  endtask

  task automatic load_tx(input logic [7:0] w);
    @(negedge pclk);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge pclk);
    tx_valid = 1'b0;
  endtask

  task automatic pop_rx();
    @(negedge pclk);
    rx_ready = 1'b1;
    @(negedge pclk);
    rx_ready = 1'b0;
  endtask

  // Master side of a frame; sclk half period is 8 pclk.
  task automatic spi_xfer(input logic cpol, input logic cpha, input logic lsb,
                          input logic [39:0] mosi, input int nbits, input bit end_frame,
                          output logic [39:0] miso);
    logic b;
    miso = '0;
    @(negedge pclk);
    cfg_cpol      = cpol;
    cfg_cpha      = cpha;
    cfg_lsb_first = lsb;
    sclk_in       = cpol;
    repeat (4) @(negedge pclk);
    n_ss_in = 1'b0;
    if (!cpha) si = mbit(mosi, 0, lsb);
    half_sclk();
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        b       = so;
        sclk_in = ~cpol;
        half_sclk();
        sclk_in = cpol;
        if (i + 1 < nbits) si = mbit(mosi, i + 1, lsb);
        half_sclk();
      end else begin
        sclk_in = ~cpol;
        si      = mbit(mosi, i, lsb);
        half_sclk();
        b       = so;
        sclk_in = cpol;
        half_sclk();
      end
      miso[8*(i/8) + (lsb ? (i % 8) : 7 - (i % 8))] = b;
    end
    if (end_frame) begin
      n_ss_in = 1'b1;
      repeat (10) @(negedge pclk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (so !== 1'b0) begin n_fail++; $display("FAIL reset_so: got %b want 0", so); end
    n_tests++; if (n_so_en !== 1'b1) begin n_fail++; $display("FAIL reset_n_so_en: got %b want 1", n_so_en); end
    n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_mode0_msb();
    logic [39:0] m;
    int u0, p0;
    do_reset();
    load_tx(8'hA5);
    n_tests++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL m0_tx_ready_full: got %b want 0", tx_ready); end
    u0 = under_cnt; p0 = push_cnt;
    spi_xfer(1'b0, 1'b0, 1'b0, 40'h3C, 8, 1'b1, m);
    n_tests++; if (m[7:0] !== 8'hA5) begin n_fail++; $display("FAIL m0_miso: got %h want a5", m[7:0]); end
    n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL m0_rx_valid: got %b want 1", rx_valid); end
    n_tests++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL m0_rx_data: got %h want 3c", rx_data); end
    n_tests++; if (push_cnt - p0 !== 1) begin n_fail++; $display("FAIL m0_push_count: got %0d want 1", push_cnt - p0); end
    n_tests++; if (under_cnt - u0 !== 0) begin n_fail++; $display("FAIL m0_underrun: got %0d want 0", under_cnt - u0); end
    n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL m0_tx_ready_empty: got %b want 1", tx_ready); end
    pop_rx();
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL m0_rx_pop: got %b want 0", rx_valid); end
  endtask

  task automatic test_mode3_lsb();
    logic [39:0] m;
    do_reset();
    load_tx(8'h81);
    spi_xfer(1'b1, 1'b1, 1'b1, 40'h55, 8, 1'b1, m);
    n_tests++; if (m[7:0] !== 8'h81) begin n_fail++; $display("FAIL m3_miso: got %h want 81", m[7:0]); end
    n_tests++; if (rx_data !== 8'h55) begin n_fail++; $display("FAIL m3_rx_data: got %h want 55", rx_data); end
    n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL m3_rx_valid: got %b want 1", rx_valid); end
  endtask

  task automatic test_underrun();
    logic [39:0] m;
    int u0;
    do_reset();
    u0 = under_cnt;
    spi_xfer(1'b0, 1'b1, 1'b0, 40'h96, 8, 1'b1, m);
    n_tests++; if (m[7:0] !== 8'hFF) begin n_fail++; $display("FAIL ur_miso: got %h want ff", m[7:0]); end
    n_tests++; if (under_cnt - u0 !== 1) begin n_fail++; $display("FAIL ur_count: got %0d want 1", under_cnt - u0); end
    n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL ur_tx_ready: got %b want 1", tx_ready); end
    n_tests++; if (rx_data !== 8'h96) begin n_fail++; $display("FAIL ur_rx_data: got %h want 96", rx_data); end
  endtask

  task automatic test_back_to_back();
    logic [39:0] m;
    int o0, u0;
    do_reset();
    o0 = over_cnt; u0 = under_cnt;
`ifdef SPI_SLV_RX_FIFO_EN
    spi_xfer(1'b0, 1'b0, 1'b0, 40'h55_44_33_22_11, 40, 1'b1, m);
    n_tests++; if (over_cnt - o0 !== 1) begin n_fail++; $display("FAIL b2b_overrun: got %0d want 1", over_cnt - o0); end
    n_tests++; if (under_cnt - u0 !== 5) begin n_fail++; $display("FAIL b2b_underrun: got %0d want 5", under_cnt - u0); end
    for (int k = 0; k < 4; k++) begin
      logic [7:0] exp_w;
      exp_w = 8'(8'h11 * (k + 1));
      n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_fifo_valid%0d: got %b want 1", k, rx_valid); end
      n_tests++; if (rx_data !== exp_w) begin n_fail++; $display("FAIL b2b_fifo_data%0d: got %h want %h", k, rx_data, exp_w); end
      pop_rx();
    end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_fifo_empty: got %b want 0", rx_valid); end
`else
    spi_xfer(1'b0, 1'b0, 1'b0, 40'h22_11, 16, 1'b1, m);
    n_tests++; if (m[15:0] !== 16'hFFFF) begin n_fail++; $display("FAIL b2b_miso: got %h want ffff", m[15:0]); end
    n_tests++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL b2b_rx_data: got %h want 11", rx_data); end
    n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_rx_valid: got %b want 1", rx_valid); end
    n_tests++; if (over_cnt - o0 !== 1) begin n_fail++; $display("FAIL b2b_overrun: got %0d want 1", over_cnt - o0); end
    n_tests++; if (under_cnt - u0 !== 2) begin n_fail++; $display("FAIL b2b_underrun: got %0d want 2", under_cnt - u0); end
`endif
  endtask

  task automatic test_abort();
    logic [39:0] m;
    int p0, o0;
    do_reset();
    p0 = push_cnt; o0 = over_cnt;
    spi_xfer(1'b0, 1'b0, 1'b0, 40'hE0, 3, 1'b0, m);
    n_tests++; if (n_so_en !== 1'b0) begin n_fail++; $display("FAIL ab_en_active: got %b want 0", n_so_en); end
    n_ss_in = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    n_tests++; if (n_so_en !== 1'b1) begin n_fail++; $display("FAIL ab_en_release: got %b want 1", n_so_en); end
    repeat (10) @(negedge pclk);
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ab_rx_valid: got %b want 0", rx_valid); end
    n_tests++; if (push_cnt - p0 !== 0) begin n_fail++; $display("FAIL ab_push: got %0d want 0", push_cnt - p0); end
    n_tests++; if (over_cnt - o0 !== 0) begin n_fail++; $display("FAIL ab_overrun: got %0d want 0", over_cnt - o0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ab_busy: got %b want 0", busy); end
    load_tx(8'hC3);
    spi_xfer(1'b0, 1'b0, 1'b0, 40'h5A, 8, 1'b1, m);
    n_tests++; if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL ab_next_rx: got %h want 5a", rx_data); end
    n_tests++; if (m[7:0] !== 8'hC3) begin n_fail++; $display("FAIL ab_next_miso: got %h want c3", m[7:0]); end
  endtask

  task automatic test_reset_mid_frame();
    logic [39:0] m;
    do_reset();
    spi_xfer(1'b0, 1'b0, 1'b0, 40'h77, 8, 1'b1, m);
    @(negedge pclk);
    n_ss_in = 1'b0;
    half_sclk();
    sclk_in = 1'b1;
    half_sclk();
    sclk_in = 1'b0;
    half_sclk();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy_before: got %b want 1", busy); end
    n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rm_valid_before: got %b want 1", rx_valid); end
    #2;
    p_reset = 1'b1;
    #1;
    n_tests++; if (n_so_en !== 1'b1) begin n_fail++; $display("FAIL rm_n_so_en: got %b want 1", n_so_en); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rm_rx_valid: got %b want 0", rx_valid); end
    n_ss_in = 1'b1;
    sclk_in = 1'b0;
    repeat (3) @(negedge pclk);
    p_reset = 1'b0;
    repeat (4) @(negedge pclk);
    load_tx(8'h3A);
    spi_xfer(1'b1, 1'b0, 1'b0, 40'hE7, 8, 1'b1, m);
    n_tests++; if (m[7:0] !== 8'h3A) begin n_fail++; $display("FAIL rm_next_miso: got %h want 3a", m[7:0]); end
    n_tests++; if (rx_data !== 8'hE7) begin n_fail++; $display("FAIL rm_next_rx: got %h want e7", rx_data); end
    n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rm_next_valid: got %b want 1", rx_valid); end
  endtask

  initial begin
    test_reset();
    test_mode0_msb();
    test_mode3_lsb();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
